// File: rtl/nr_kernel_cfg.sv
// nr_kernel_cfg
//   Double-buffered configuration store for a noise-reduction kernel: a 7x7
//   space weight table plus a 9-point colour curve (x and y).  Software
//   writes the shadow bank, requests a commit, and the whole shadow bank is
//   copied into the active bank on the next frame start.  The outputs only
//   ever show a complete kernel.
//
//   Optional feature: define NR_KCFG_MONO_CHECK_EN to verify that curve x
//   is strictly increasing before a commit is accepted.  Without it a
//   commit goes straight to waiting for the frame start and cfg_err[1]
//   stays 0.
//
// Ports
//   pclk, rst_n       clock, asynchronous active-low reset
//   cfg_wr_en         shadow write strobe (cfg_addr, cfg_wdata)
//   cfg_addr          0-48 weight row*7+col, 49-57 curve x, 58-66 curve y
//   cfg_wdata         write data (weights / curve y use the low bits)
//   cfg_commit        request to apply the shadow bank at the next frame
//   cfg_err_clr       clears the sticky error flags
//   in_vsync          frame sync, rising edge = frame start
//   cfg_busy          commit in progress
//   cfg_err           [0] dropped write, [1] curve x not increasing
//   kernel_updated    one-cycle pulse while the freshly loaded bank shows
//   space_kernel      active weights, entry i at [i*WEIGHT_BITS +: WEIGHT_BITS]
//   color_curve_x     active curve x, point k at [k*BITS +: BITS]
//   color_curve_y     active curve y, point k at [k*WEIGHT_BITS +: WEIGHT_BITS]
//
// state  | meaning
// IDLE   | shadow writable, waiting for cfg_commit
// CHECK  | 8 cycles, one curve x pair compared per cycle (macro only)
// PEND   | commit accepted, waiting for a vsync rising edge
// APPLY  | active bank just loaded, kernel_updated high

module nr_kernel_cfg #(
   parameter int WEIGHT_BITS = 5,
   parameter int BITS        = 8
) (
   input  logic                      pclk,
   input  logic                      rst_n,
   input  logic                      cfg_wr_en,
   input  logic [6:0]                cfg_addr,
   input  logic [7:0]                cfg_wdata,
   input  logic                      cfg_commit,
   input  logic                      cfg_err_clr,
   input  logic                      in_vsync,
   output logic                      cfg_busy,
   output logic [1:0]                cfg_err,
   output logic                      kernel_updated,
   output logic [49*WEIGHT_BITS-1:0] space_kernel,
   output logic [9*BITS-1:0]         color_curve_x,
   output logic [9*WEIGHT_BITS-1:0]  color_curve_y
);

   localparam int N_W     = 49;
   localparam int N_PT    = 9;
   localparam int ADDR_CX = 49;
   localparam int ADDR_CY = 58;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef NR_KCFG_MONO_CHECK_EN
      ST_CHECK = 2'd1,
`endif
      ST_PEND  = 2'd2,
      ST_APPLY = 2'd3
   } state_t;

   // Reset weights: rows 4-6 mirror rows 2-0 and every row is symmetric
   // about column 3, so only a quarter of the table needs describing.
   function automatic logic [WEIGHT_BITS-1:0] dflt_w(input int idx);
      int row;
      int col;
      int v;
      row = idx / 7;
      col = idx % 7;
      if (row > 3) row = 6 - row;
      if (col > 3) col = 6 - col;
      v = 0;
      case (row)
         0: case (col)
               0:       v = 28;
               1, 2:    v = 29;
               default: v = 30;
            endcase
         1: v = (col == 0) ? 29 : 30;
         2: case (col)
               0:       v = 29;
               1:       v = 30;
               default: v = 31;
            endcase
         default: v = (col < 2) ? 30 : 31;
      endcase
      return WEIGHT_BITS'(v);
   endfunction

   function automatic logic [BITS-1:0] dflt_cx(input int k);
      int v;
      case (k)
         0:       v = 3;
         1:       v = 6;
         2:       v = 10;
         3:       v = 13;
         4:       v = 17;
         5:       v = 20;
         6:       v = 23;
         7:       v = 27;
         default: v = 30;
      endcase
      return BITS'(v);
   endfunction

   function automatic logic [WEIGHT_BITS-1:0] dflt_cy(input int k);
      int v;
      case (k)
         0:       v = 30;
         1:       v = 26;
         2:       v = 19;
         3:       v = 13;
         4:       v = 7;
         5:       v = 4;
         6:       v = 2;
         7:       v = 1;
         default: v = 0;
      endcase
      return WEIGHT_BITS'(v);
   endfunction

   logic [WEIGHT_BITS-1:0] sh_w  [N_W];
   logic [BITS-1:0]        sh_cx [N_PT];
   logic [WEIGHT_BITS-1:0] sh_cy [N_PT];
   logic [WEIGHT_BITS-1:0] act_w [N_W];
   logic [BITS-1:0]        act_cx[N_PT];
   logic [WEIGHT_BITS-1:0] act_cy[N_PT];

   state_t     state_q;
   state_t     state_d;
   logic       vsync_q;
   logic       vsync_edge;
   logic       wr_ok;
   logic       wr_bad;
   logic       load_active;
   logic [1:0] err_q;
   logic [1:0] err_set;

`ifdef NR_KCFG_MONO_CHECK_EN
   logic [2:0] chk_cnt_q;
   logic [2:0] chk_cnt_d;
   logic       chk_fail_q;
   logic       chk_fail_d;
   logic       pair_ok;

   // Down-counter selects the pair: cnt=7 checks cx[7]<cx[8], cnt=0 checks
   // cx[0]<cx[1].  The shadow cannot change outside IDLE, so the pairs
   // all see the same snapshot.
   always_comb begin
      pair_ok = 1'b1;
      for (int k = 0; k < N_PT - 1; k++) begin
         if (chk_cnt_q == 3'(k)) pair_ok = (sh_cx[k] < sh_cx[k+1]);
      end
   end
`endif

   assign vsync_edge  = in_vsync & ~vsync_q;
   assign wr_ok       = cfg_wr_en && (state_q == ST_IDLE) && (cfg_addr <= 7'd66);
   assign wr_bad      = cfg_wr_en && !wr_ok;
   assign load_active = (state_q == ST_PEND) && vsync_edge;

   always_comb begin
      state_d    = state_q;
      err_set    = 2'b00;
      err_set[0] = wr_bad;
`ifdef NR_KCFG_MONO_CHECK_EN
      chk_cnt_d  = chk_cnt_q;
      chk_fail_d = chk_fail_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cfg_commit) begin
`ifdef NR_KCFG_MONO_CHECK_EN
               state_d    = ST_CHECK;
               chk_cnt_d  = 3'd7;
               chk_fail_d = 1'b0;
`else
               state_d    = ST_PEND;
`endif
            end
         end
`ifdef NR_KCFG_MONO_CHECK_EN
         ST_CHECK: begin
            if (!pair_ok) begin
               err_set[1] = 1'b1;
               chk_fail_d = 1'b1;
            end
            if (chk_cnt_q == 3'd0) begin
               state_d = (chk_fail_q || !pair_ok) ? ST_IDLE : ST_PEND;
            end else begin
               chk_cnt_d = chk_cnt_q - 3'd1;
            end
         end
`endif
         ST_PEND: begin
            if (vsync_edge) state_d = ST_APPLY;
         end
         ST_APPLY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         vsync_q    <= 1'b0;
         err_q      <= 2'b00;
`ifdef NR_KCFG_MONO_CHECK_EN
         chk_cnt_q  <= 3'd0;
         chk_fail_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         vsync_q    <= in_vsync;
         // A set in the same cycle as the clear wins.
         err_q      <= (err_q & ~{2{cfg_err_clr}}) | err_set;
`ifdef NR_KCFG_MONO_CHECK_EN
         chk_cnt_q  <= chk_cnt_d;
         chk_fail_q <= chk_fail_d;
`endif
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_W; i++) begin
            sh_w[i]  <= dflt_w(i);
            act_w[i] <= dflt_w(i);
         end
         for (int k = 0; k < N_PT; k++) begin
            sh_cx[k]  <= dflt_cx(k);
            act_cx[k] <= dflt_cx(k);
            sh_cy[k]  <= dflt_cy(k);
            act_cy[k] <= dflt_cy(k);
         end
      end else begin
         if (wr_ok) begin
            for (int i = 0; i < N_W; i++) begin
               if (cfg_addr == 7'(i)) sh_w[i] <= WEIGHT_BITS'(cfg_wdata);
            end
            for (int k = 0; k < N_PT; k++) begin
               if (cfg_addr == 7'(ADDR_CX + k)) sh_cx[k] <= BITS'(cfg_wdata);
               if (cfg_addr == 7'(ADDR_CY + k)) sh_cy[k] <= WEIGHT_BITS'(cfg_wdata);
            end
         end
         // Loaded on the PEND->APPLY transition so the new kernel is
         // visible for the whole APPLY cycle, together with kernel_updated.
         if (load_active) begin
            act_w  <= sh_w;
            act_cx <= sh_cx;
            act_cy <= sh_cy;
         end
      end
   end

   assign cfg_busy       = (state_q != ST_IDLE);
   assign kernel_updated = (state_q == ST_APPLY);
   assign cfg_err        = err_q;

   for (genvar g = 0; g < N_W; g++) begin : g_w
      assign space_kernel[g*WEIGHT_BITS +: WEIGHT_BITS] = act_w[g];
   end

   for (genvar g = 0; g < N_PT; g++) begin : g_pt
      assign color_curve_x[g*BITS +: BITS]               = act_cx[g];
      assign color_curve_y[g*WEIGHT_BITS +: WEIGHT_BITS] = act_cy[g];
   end

endmodule

// File: tb/tb_nr_kernel_cfg.sv
module tb_nr_kernel_cfg;

   localparam int WB    = 5;
   localparam int B     = 8;
   localparam int WMASK = (1 << WB) - 1;
   localparam int BMASK = (1 << B) - 1;
`ifdef NR_KCFG_MONO_CHECK_EN
   localparam bit MONO = 1'b1;
   localparam int LAT  = 9;
`else
   localparam bit MONO = 1'b0;
   localparam int LAT  = 1;
`endif

   logic             pclk;
   logic             rst_n;
   logic             cfg_wr_en;
   logic [6:0]       cfg_addr;
   logic [7:0]       cfg_wdata;
   logic             cfg_commit;
   logic             cfg_err_clr;
   logic             in_vsync;
   logic             cfg_busy;
   logic [1:0]       cfg_err;
   logic             kernel_updated;
   logic [49*WB-1:0] space_kernel;
   logic [9*B-1:0]   color_curve_x;
   logic [9*WB-1:0]  color_curve_y;

   nr_kernel_cfg #(.WEIGHT_BITS(WB), .BITS(B)) dut (
      .pclk           (pclk),
      .rst_n          (rst_n),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_addr       (cfg_addr),
      .cfg_wdata      (cfg_wdata),
      .cfg_commit     (cfg_commit),
      .cfg_err_clr    (cfg_err_clr),
      .in_vsync       (in_vsync),
      .cfg_busy       (cfg_busy),
      .cfg_err        (cfg_err),
      .kernel_updated (kernel_updated),
      .space_kernel   (space_kernel),
      .color_curve_x  (color_curve_x),
      .color_curve_y  (color_curve_y)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct packed {
      logic [49*WB-1:0] w;
      logic [9*B-1:0]   cx;
      logic [9*WB-1:0]  cy;
   } bank_t;

   typedef struct packed {
      bank_t b;
      int    at;
   } exp_t;

   exp_t       exp_q[$];
   int         sh_w [49];
   int         sh_cx[9];
   int         sh_cy[9];
   bank_t      act_m;
   bank_t      dflt_bank;
   logic [1:0] err_m;
   int         n_chk  = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;
   bit         exp_pulse;

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick();
   endtask

   // Reference values written straight from the table: 4 listed rows, the
   // remaining rows are the mirror of rows 2..0.
   task automatic load_defaults();
      int rows[4][7];
      int cx_d[9];
      int cy_d[9];
      rows = '{'{28, 29, 29, 30, 29, 29, 28},
               '{29, 30, 30, 30, 30, 30, 29},
               '{29, 30, 31, 31, 31, 30, 29},
               '{30, 30, 31, 31, 31, 30, 30}};
      cx_d = '{3, 6, 10, 13, 17, 20, 23, 27, 30};
      cy_d = '{30, 26, 19, 13, 7, 4, 2, 1, 0};
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++)
            sh_w[r*7 + c] = rows[(r < 4) ? r : 6 - r][c];
      for (int k = 0; k < 9; k++) begin
         sh_cx[k] = cx_d[k];
         sh_cy[k] = cy_d[k];
      end
   endtask

   function automatic bank_t pack_shadow();
      bank_t r;
      for (int i = 0; i < 49; i++) r.w[i*WB +: WB] = WB'(sh_w[i]);
      for (int k = 0; k < 9; k++) begin
         r.cx[k*B +: B]   = B'(sh_cx[k]);
         r.cy[k*WB +: WB] = WB'(sh_cy[k]);
      end
      return r;
   endfunction

   function automatic bank_t cur_bank();
      return {space_kernel, color_curve_x, color_curve_y};
   endfunction

   function automatic bit mono_ok();
      for (int k = 0; k < 8; k++)
         if (!(sh_cx[k] < sh_cx[k+1])) return 1'b0;
      return 1'b1;
   endfunction

   // Monitor: the scheduled pulse cycle must match exactly, and outputs
   // must equal the last applied bank on every cycle.
   always @(negedge pclk) begin
      if (mon_en) begin
         exp_pulse = (exp_q.size() > 0) && (exp_q[0].at == cyc);
         chk("kernel_updated", kernel_updated, exp_pulse);
         if (exp_pulse) begin
            act_m = exp_q[0].b;
            void'(exp_q.pop_front());
         end
         chk("active_outputs", cur_bank(), act_m);
      end
   end

   task automatic wr(input int a, input int d);
      cfg_wr_en = 1'b1;
      cfg_addr  = 7'(a);
      cfg_wdata = 8'(d);
      tick();
      cfg_wr_en = 1'b0;
      if (a < 49)      sh_w[a]       = d & WMASK;
      else if (a < 58) sh_cx[a - 49] = d & BMASK;
      else if (a < 67) sh_cy[a - 58] = d & WMASK;
      else             err_m[0]      = 1'b1;
   endtask

   task automatic err_clear();
      cfg_err_clr = 1'b1;
      tick();
      cfg_err_clr = 1'b0;
      err_m = 2'b00;
      chk("err_after_clr", cfg_err, err_m);
   endtask

   task automatic commit_frame(input int vs_delay, input bit pend_wr, input bit early);
      int    t0;
      bit    ok;
      bank_t b;
      ok = MONO ? mono_ok() : 1'b1;
      b  = pack_shadow();
      cfg_commit = 1'b1;
      t0 = cyc;
      if (early && LAT == 1) in_vsync = 1'b1;
      tick();
      cfg_commit = 1'b0;
      chk("busy_after_commit", cfg_busy, 1'b1);
      if (pend_wr) begin
         cfg_wr_en = 1'b1;
         cfg_addr  = 7'd0;
         cfg_wdata = 8'h55;
         tick();
         cfg_wr_en = 1'b0;
         err_m[0]  = 1'b1;
         chk("err_pend_write", cfg_err[0], 1'b1);
      end
      if (early) begin
         wait_until(t0 + LAT - 1);
         in_vsync = 1'b1;
         tick();
         tick();
         chk("busy_after_early_edge", cfg_busy, 1'b1);
         in_vsync = 1'b0;
         tick();
      end
      if (ok) begin
         wait_until(t0 + LAT + vs_delay);
         chk("busy_in_pend", cfg_busy, 1'b1);
         in_vsync = 1'b1;
         exp_q.push_back('{b: b, at: cyc + 1});
         tick();
         tick();
         tick();
         in_vsync = 1'b0;
      end else begin
         err_m[1] = 1'b1;
         wait_until(t0 + LAT + 1);
         in_vsync = 1'b1;
         tick();
         tick();
         in_vsync = 1'b0;
         tick();
      end
      chk("busy_done", cfg_busy, 1'b0);
      chk("cfg_err", cfg_err, err_m);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic random_round();
      int nw;
      int p;
      int a;
      int d;
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
         p = $urandom_range(0, 99);
         if (p < 8) a = $urandom_range(67, 127);
         else if (p < 25) a = $urandom_range(49, 57);
         else begin
            a = $urandom_range(0, 57);
            if (a >= 49) a = a + 9;
         end
         d = (a >= 49 && a <= 57) ? $urandom_range(0, 40) : $urandom_range(0, 255);
         wr(a, d);
      end
      if (!mono_ok() && $urandom_range(0, 1) == 1)
         for (int k = 0; k < 9; k++) wr(49 + k, 3*k + $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
         in_vsync = 1'b1;
         tick();
         tick();
         in_vsync = 1'b0;
         tick();
      end
      commit_frame($urandom_range(0, 3), $urandom_range(0, 3) == 0, 1'b0);
      if ($urandom_range(0, 2) == 0) err_clear();
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: summary not reached, required completion within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b0;
      cfg_wr_en   = 1'b0;
      cfg_addr    = 7'd0;
      cfg_wdata   = 8'd0;
      cfg_commit  = 1'b0;
      cfg_err_clr = 1'b0;
      in_vsync    = 1'b0;
      load_defaults();
      dflt_bank = pack_shadow();
      act_m     = dflt_bank;
      err_m     = 2'b00;
      #1;
      mon_en = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      chk("reset_w24", space_kernel[24*WB +: WB], 31);
      chk("reset_w0", space_kernel[0 +: WB], 28);
      chk("reset_cx8", color_curve_x[8*B +: B], 30);
      chk("reset_busy", cfg_busy, 1'b0);
      chk("reset_err", cfg_err, 2'b00);
      chk("reset_bank", cur_bank(), dflt_bank);

      // new weight only visible after the frame edge
      wr(24, 5);
      chk("w24_before_commit", space_kernel[24*WB +: WB], 31);
      commit_frame(0, 1'b0, 1'b0);
      chk("w24_after_apply", space_kernel[24*WB +: WB], 5);

      // cx3 below cx2
      wr(52, 9);
      commit_frame(0, 1'b0, 1'b0);
      if (MONO) chk("err_mono", cfg_err, 2'b10);
      err_clear();
      wr(52, 13);

      // vsync edge one cycle before PEND is ignored
      wr(60, 11);
      commit_frame(0, 1'b0, 1'b1);

      // illegal address; clear in the same cycle as a new set keeps the bit
      wr(70, 8'hAA);
      chk("err_illegal", cfg_err, 2'b01);
      cfg_wr_en   = 1'b1;
      cfg_addr    = 7'd100;
      cfg_err_clr = 1'b1;
      tick();
      cfg_wr_en   = 1'b0;
      cfg_err_clr = 1'b0;
      chk("err_set_beats_clr", cfg_err, 2'b01);
      err_clear();
      commit_frame(1, 1'b0, 1'b0);

      // write during the pending commit is dropped
      wr(0, 17);
      commit_frame(1, 1'b1, 1'b0);
      chk("w0_pre_commit", space_kernel[0 +: WB], 17);
      err_clear();

      for (int r = 0; r < 40; r++) random_round();

      // reset while a commit is pending
      err_clear();
      for (int k = 0; k < 9; k++) wr(49 + k, 3*k + 1);
      wr(5, 3);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      repeat (LAT + 1) tick();
      chk("busy_before_reset", cfg_busy, 1'b1);
      rst_n = 1'b0;
      load_defaults();
      act_m = dflt_bank;
      err_m = 2'b00;
      exp_q.delete();
      #1;
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_kupd", kernel_updated, 1'b0);
      chk("rst_err", cfg_err, 2'b00);
      chk("rst_bank", cur_bank(), dflt_bank);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      in_vsync = 1'b1;
      repeat (3) tick();
      in_vsync = 1'b0;
      tick();
      chk("post_rst_busy", cfg_busy, 1'b0);
      chk("post_rst_w24", space_kernel[24*WB +: WB], 31);
      chk("final_queue", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nr_kernel_cfg.md
NR_KERNEL_CFG -- requirements
Module: nr_kernel_cfg

Interface
REQ-001 Parameter WEIGHT_BITS, default 5, bit width of each space weight and each curve y point.
REQ-002 Parameter BITS, default 8, bit width of each curve x point.
REQ-003 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_wr_en  input  1  write strobe into the shadow bank.
REQ-006 cfg_addr  input  7  entry index: 0-48 space weight (row*7+col), 49-57 curve x 0-8, 58-66 curve y 0-8.
REQ-007 cfg_wdata  input  8  write data; weight and curve y entries take bits [WEIGHT_BITS-1:0].
REQ-008 cfg_commit  input  1  single-cycle request to apply the shadow bank at the next frame start.
REQ-009 cfg_err_clr  input  1  clears cfg_err.
REQ-010 in_vsync  input  1  frame sync, active high; a rising edge marks the frame start.
REQ-011 cfg_busy  output  1  high while in CHECK, PEND or APPLY.
REQ-012 cfg_err  output  2  sticky flags: [0] illegal write, [1] curve x non-monotonic.
REQ-013 kernel_updated  output  1  one-cycle pulse when the active bank is loaded.
REQ-014 space_kernel  output  49*WEIGHT_BITS  active weights; entry i at [i*WEIGHT_BITS +: WEIGHT_BITS].
REQ-015 color_curve_x  output  9*BITS  active curve x; point k at [k*BITS +: BITS].
REQ-016 color_curve_y  output  9*WEIGHT_BITS  active curve y; point k at [k*WEIGHT_BITS +: WEIGHT_BITS].

Function
REQ-017 The block SHALL hold a shadow bank and an active bank of 67 entries each; outputs are driven only from the active bank.
REQ-018 The FSM SHALL have states IDLE, CHECK, PEND and APPLY.
REQ-019 In IDLE, a write with cfg_addr<=66 SHALL update the shadow entry; cfg_addr>=67 SHALL be dropped and set cfg_err[0].
REQ-020 A write in any state other than IDLE SHALL be dropped and set cfg_err[0].
REQ-021 cfg_commit in IDLE SHALL enter CHECK next cycle; a write in the same cycle SHALL be applied first and included in the check.
REQ-022 cfg_commit outside IDLE SHALL be ignored without error.
REQ-023 CHECK SHALL last 8 cycles, comparing shadow cx[k] < cx[k+1] for k=0..7, one pair per cycle.
REQ-024 Any failed comparison SHALL set cfg_err[1] and return to IDLE after CHECK, leaving the active bank unchanged.
REQ-025 A passed CHECK SHALL enter PEND; commit at cycle T puts PEND at T+9.
REQ-026 in_vsync SHALL be registered once; an edge is detected in the cycle where in_vsync is 1 and the registered copy is 0.
REQ-027 Only an edge detected while in PEND SHALL move the FSM to APPLY; edges in other states SHALL be ignored.
REQ-028 In APPLY the active bank SHALL load the whole shadow bank in one cycle, kernel_updated SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE.
REQ-029 Outputs SHALL change only on the APPLY load, so a frame never sees a partial kernel.
REQ-030 cfg_err bits SHALL stay set until cfg_err_clr; a set event and cfg_err_clr in the same cycle SHALL leave the bit set.

Reset
REQ-031 Reset SHALL put the FSM in IDLE, drop any pending commit, and clear cfg_err, cfg_busy, kernel_updated and the vsync register.
REQ-032 Both banks SHALL reset to the space weights below, with rows 4-6 mirroring rows 2-0.
- row0 28,29,29,30,29,29,28
- row1 29,30,30,30,30,30,29
- row2 29,30,31,31,31,30,29
- row3 30,30,31,31,31,30,30
REQ-033 Both banks SHALL reset to curve x 3,6,10,13,17,20,23,27,30 and curve y 30,26,19,13,7,4,2,1,0.

Configuration
REQ-034 With macro NR_KCFG_MONO_CHECK_EN defined, CHECK SHALL behave as in REQ-023/024.
REQ-035 Without NR_KCFG_MONO_CHECK_EN, there SHALL be no CHECK state: commit goes straight to PEND at T+1, and cfg_err[1] is tied to 0.

Verification
REQ-036 Release reset, then hold:
- space_kernel entry 24 = 31, entry 0 = 28; color_curve_x point 8 = 30; cfg_busy = 0.
REQ-037 Write addr 24=5, then commit, then vsync rise:
- before the vsync edge, output entry 24 is still 31;
- after APPLY, entry 24 = 5 with a single kernel_updated pulse.
REQ-038 Write addr 52 (cx3)=9, which is below cx2=10, then commit:
- with the macro: cfg_err=2'b10, back to IDLE, no update on the next vsync;
- without the macro: updates on the next vsync.
REQ-039 Write addr 70:
- cfg_err[0]=1 and the shadow is unchanged;
- cfg_err_clr clears it.
REQ-040 Commit, then a write to addr 0 during PEND:
- the write is dropped and cfg_err[0]=1;
- apply uses the pre-commit shadow.
REQ-041 Assert rst_n low during PEND:
- outputs are back to defaults and the FSM is in IDLE;
- the next vsync edge causes no kernel_updated pulse.
